// File: rtl/banner_pkg.sv
// rtl/banner_pkg.sv - shared types and constants for the status-banner overlay sequencer
package banner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLINK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam int BANNER_WCHECKMATE = 0;
    localparam int BANNER_BCHECKMATE = 1;
    localparam int BANNER_STALEMATE  = 2;
    localparam int BANNER_CHECK      = 3;

    localparam logic [9:0] TICK_X = 10'd0;
    localparam logic [9:0] TICK_Y = 10'd480;

endpackage

// File: rtl/frame_tick_gen.sv
// rtl/frame_tick_gen.sv - one-cycle pulse on the first cycle the raster reaches the tick position
module frame_tick_gen
    import banner_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    output logic       tick
);

    logic match_d;
    logic match_q;

    always_comb begin
        match_d = (draw_x == TICK_X) && (draw_y == TICK_Y);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    // A raster that lingers on the tick position still yields a single pulse.
    assign tick = match_d & ~match_q;

endmodule

// File: rtl/banner_sequencer.sv
// rtl/banner_sequencer.sv - arbitrates end-of-game banners, blinks then holds, muxes the overlay pixel
module banner_sequencer
    import banner_pkg::*;
#(
    parameter int NUM_BANNERS  = 4,
    parameter int BLINK_FRAMES = 30,
    parameter int BLINK_CYCLES = 3
) (
    input  logic                      vga_clk,
    input  logic                      reset,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic                      blank,
    input  logic [NUM_BANNERS-1:0]    req,
    input  logic                      clear,
    input  logic [NUM_BANNERS-1:0]    sprite_on,
    input  logic [12*NUM_BANNERS-1:0] sprite_rgb,
    output logic                      overlay_on,
    output logic [3:0]                red,
    output logic [3:0]                green,
    output logic [3:0]                blue,
    output logic [1:0]                banner_sel,
    output logic                      busy
);

    localparam int SEL_W   = 2;
    localparam int FCNT_W  = $clog2(BLINK_FRAMES + 1);
    localparam int PHASE_W = $clog2(2 * BLINK_CYCLES + 1);
    localparam logic [FCNT_W-1:0]  FCNT_LAST  = FCNT_W'(BLINK_FRAMES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(2 * BLINK_CYCLES - 1);

    state_t               state_q, state_d;
    logic [NUM_BANNERS-1:0] req_q, req_d;
    logic [SEL_W-1:0]     sel_next_q, sel_next_d;
    logic [SEL_W-1:0]     sel_frame_q, sel_frame_d;
    logic                 show_frame_q, show_frame_d;
    logic [FCNT_W-1:0]    fcnt_q, fcnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;

    logic                 tick;
    logic [NUM_BANNERS-1:0] rise;
    logic                 any_rise;
    logic [SEL_W-1:0]     winner;
    logic                 show_next;
    logic                 sel_sprite_on;
    logic [11:0]          sel_sprite_rgb;

    frame_tick_gen u_tick (
        .clk    (vga_clk),
        .rst    (reset),
        .draw_x (DrawX),
        .draw_y (DrawY),
        .tick   (tick)
    );

    always_comb begin
        req_d    = req;
        rise     = req & ~req_q;
        any_rise = |rise;
        winner   = '0;
        for (int i = NUM_BANNERS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                winner = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            sel_next_q   <= SEL_W'(BANNER_WCHECKMATE);
            sel_frame_q  <= SEL_W'(BANNER_WCHECKMATE);
            show_frame_q <= 1'b0;
            fcnt_q       <= '0;
            phase_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            sel_next_q   <= sel_next_d;
            sel_frame_q  <= sel_frame_d;
            show_frame_q <= show_frame_d;
            fcnt_q       <= fcnt_d;
            phase_q      <= phase_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_next_d   = sel_next_q;
        sel_frame_d  = sel_frame_q;
        show_frame_d = show_frame_q;
        fcnt_d       = fcnt_q;
        phase_d      = phase_q;

        // The frame latch always sees pre-update values; clear/preempt below override the advance.
        if (tick) begin
            sel_frame_d  = sel_next_q;
            show_frame_d = show_next;
            if (state_q == ST_BLINK) begin
                if (fcnt_q == FCNT_LAST) begin
                    fcnt_d = '0;
                    if (phase_q == PHASE_LAST) begin
                        state_d = ST_HOLD;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
        end

        if (clear) begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
            phase_d = '0;
        end else if (any_rise && (state_q == ST_IDLE || winner < sel_next_q)) begin
            state_d    = ST_BLINK;
            sel_next_d = winner;
            fcnt_d     = '0;
            phase_d    = '0;
        end
    end

    always_comb begin
        show_next = 1'b0;
        case (state_q)
            ST_BLINK: show_next = ~phase_q[0];
            ST_HOLD:  show_next = 1'b1;
            default:  show_next = 1'b0;
        endcase
        busy = (state_q != ST_IDLE);
    end

    always_comb begin
        sel_sprite_on  = 1'b0;
        sel_sprite_rgb = '0;
        for (int i = 0; i < NUM_BANNERS; i++) begin
            if (sel_frame_q == SEL_W'(i)) begin
                sel_sprite_on  = sprite_on[i];
                sel_sprite_rgb = sprite_rgb[12*i +: 12];
            end
        end
        overlay_on         = show_frame_q & blank & sel_sprite_on;
        {red, green, blue} = overlay_on ? sel_sprite_rgb : 12'h000;
        banner_sel         = sel_frame_q;
    end

endmodule

// File: tb/tb_banner_sequencer.sv
// tb/tb_banner_sequencer.sv - randomized scoreboard bench for banner_sequencer against a frame-count model
module tb_banner_sequencer;

    localparam int N  = 4;
    localparam int BF = 2;
    localparam int BC = 2;
    localparam int FR = 32;

    logic            vga_clk = 1'b0;
    logic            reset   = 1'b1;
    logic [9:0]      DrawX   = 10'd0;
    logic [9:0]      DrawY   = 10'd478;
    logic            blank   = 1'b0;
    logic [N-1:0]    req     = '0;
    logic            clear   = 1'b0;
    logic [N-1:0]    sprite_on  = '0;
    logic [12*N-1:0] sprite_rgb = '0;
    logic            overlay_on;
    logic [3:0]      red, green, blue;
    logic [1:0]      banner_sel;
    logic            busy;

    banner_sequencer #(
        .NUM_BANNERS  (N),
        .BLINK_FRAMES (BF),
        .BLINK_CYCLES (BC)
    ) dut (
        .vga_clk    (vga_clk),
        .reset      (reset),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .blank      (blank),
        .req        (req),
        .clear      (clear),
        .sprite_on  (sprite_on),
        .sprite_rgb (sprite_rgb),
        .overlay_on (overlay_on),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .banner_sel (banner_sel),
        .busy       (busy)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct packed {
        logic        ov;
        logic [11:0] rgb;
        logic [1:0]  sel;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pix      = 0;

    // Model: which banner is active and how many frame ticks have elapsed since it started.
    bit           m_active     = 0;
    int           m_sel        = 0;
    int           m_k          = 0;
    int           m_sel_frame  = 0;
    bit           m_show_frame = 0;
    logic [N-1:0] m_req_prev   = '0;
    bit           m_match_prev = 0;

    function automatic bit show_for(bit act, int k);
        return act && (k >= 2*BC*BF || ((k / BF) % 2) == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_edge();
        bit           match;
        bit           tick;
        logic [N-1:0] rise;
        int           w;
        match = (DrawX == 10'd0) && (DrawY == 10'd480);
        if (reset) begin
            m_active = 0; m_sel = 0; m_k = 0; m_sel_frame = 0; m_show_frame = 0;
            m_req_prev = '0; m_match_prev = 0;
            return;
        end
        tick = match && !m_match_prev;
        m_match_prev = match;
        rise = req & ~m_req_prev;
        m_req_prev = req;
        if (tick) begin
            m_sel_frame  = m_sel;
            m_show_frame = show_for(m_active, m_k);
            if (m_active && m_k < 2*BC*BF) m_k++;
        end
        if (clear) begin
            m_active = 0;
        end else if (rise != '0) begin
            w = 0;
            for (int i = N - 1; i >= 0; i--) if (rise[i]) w = i;
            if (!m_active || w < m_sel) begin
                m_sel = w; m_active = 1; m_k = 0;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic c);
        exp_t e;
        @(posedge vga_clk);
        model_edge();
        #1;
        req        = r;
        clear      = c;
        pix        = (pix + 1) % FR;
        DrawX      = 10'(pix % 8);
        DrawY      = 10'(478 + pix / 8);
        blank      = ($urandom_range(0, 3) != 0);
        sprite_on  = N'($urandom);
        sprite_rgb = (12*N)'({$urandom, $urandom});
        e.ov   = m_show_frame & blank & sprite_on[m_sel_frame];
        e.rgb  = e.ov ? sprite_rgb[12*m_sel_frame +: 12] : 12'h000;
        e.sel  = 2'(m_sel_frame);
        e.busy = m_active;
        exp_q.push_back(e);
    endtask

    task automatic run(input logic [N-1:0] r, input int cycles);
        repeat (cycles) step(r, 1'b0);
    endtask

    always @(negedge vga_clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("overlay_on", 32'(overlay_on), 32'(e.ov));
            chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
            chk("banner_sel", 32'(banner_sel), 32'(e.sel));
            chk("busy", 32'(busy), 32'(e.busy));
        end
    end

    initial begin
        logic [N-1:0] r;
        logic         c;

        // Request already high while reset is held; counts as an edge on release.
        run(4'b0010, 3);
        reset = 1'b0;
        run(4'b0010, 12*FR);

        // Low-priority banner, then preempted by banner 0 three frames later.
        step(4'b0010, 1'b1);
        run(4'b0000, 2);
        run(4'b1000, 3*FR);
        run(4'b1001, 10*FR);

        // Lower-priority rise in HOLD is ignored.
        run(4'b1101, 2*FR);

        // clear and a new rise in the same cycle: the rise is dropped.
        step(4'b1111, 1'b1);
        run(4'b1111, 2*FR);

        // Hold on banner 1 with random blank/sprite data.
        run(4'b0000, 2);
        run(4'b0010, 12*FR);

        // Preempt landing exactly on a frame tick, then clear landing on a tick.
        step(4'b0000, 1'b1);
        run(4'b0000, 2);
        run(4'b0100, 3*FR);
        while (pix != 15) step(4'b0100, 1'b0);
        step(4'b0101, 1'b0);
        run(4'b0101, 4*FR);
        while (pix != 15) step(4'b0101, 1'b0);
        step(4'b0101, 1'b1);
        run(4'b0101, 2*FR);

        // Asynchronous reset in the middle of a frame.
        run(4'b0000, 2);
        run(4'b0010, 5*FR + 7);
        @(negedge vga_clk);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_overlay", 32'(overlay_on), 32'd0);
        chk("async_reset_rgb", 32'({red, green, blue}), 32'd0);
        chk("async_reset_sel", 32'(banner_sel), 32'd0);
        chk("async_reset_busy", 32'(busy), 32'd0);
        run(4'b0010, 3);
        reset = 1'b0;
        run(4'b0010, 3*FR);

        // Random request toggles and occasional clears.
        r = 4'b0010;
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) r[$urandom_range(0, N-1)] ^= 1'b1;
            c = ($urandom_range(0, 199) == 0);
            step(r, c);
        end

        repeat (2) @(negedge vga_clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
